// File: rtl/multicycle_controller.sv
// Multicycle RV32I control FSM: sequences fetch, decode, memory, ALU, jump and
// branch steps over a unified memory, and traps on unsupported opcodes.
module multicycle_controller #(
  parameter int ALU_CTRL_W   = 4,
  parameter bit MEM_READY_EN = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            op,
  input  logic [2:0]            func3,
  input  logic                  func7_5,
  input  logic                  alu_zero,
  input  logic                  alu_lt,
  input  logic                  alu_ltu,
  input  logic                  mem_ready,
  output logic                  pc_write,
  output logic                  ir_write,
  output logic                  reg_write,
  output logic                  mem_req,
  output logic                  mem_write,
  output logic                  adr_src,
  output logic [1:0]            alu_src_a,
  output logic [1:0]            alu_src_b,
  output logic [1:0]            result_src,
  output logic [2:0]            imm_src,
  output logic [ALU_CTRL_W-1:0] alu_ctrl,
  output logic                  illegal,
  output logic [3:0]            state_o
);

  if (ALU_CTRL_W < 4) begin : g_bad_alu_ctrl_w
    $error("multicycle_controller: ALU_CTRL_W must be at least 4");
  end

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_JAL      = 4'd9,
    S_BRANCH   = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLT  = 4'd5,
    ALU_SLTU = 4'd6,
    ALU_SLL  = 4'd7,
    ALU_SRL  = 4'd8,
    ALU_SRA  = 4'd9
  } alu_op_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  state_t  state, next_state;
  alu_op_t alu_op;
  logic    ready;
  logic    taken;

  assign ready = MEM_READY_EN ? mem_ready : 1'b1;

  // func7_5 only selects SUB for register ops; shifts honour it in both forms.
  function automatic alu_op_t decode_alu(input logic [2:0] f3, input logic f7,
                                         input logic is_rtype);
    case (f3)
      3'b000:  return (is_rtype && f7) ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return f7 ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  always_comb begin
    case (func3)
      3'b000:  taken = alu_zero;
      3'b001:  taken = !alu_zero;
      3'b100:  taken = alu_lt;
      3'b101:  taken = !alu_lt;
      3'b110:  taken = alu_ltu;
      3'b111:  taken = !alu_ltu;
      default: taken = 1'b0;
    endcase
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_FETCH;
    else     state <= next_state;
  end

  // NOTE: every output gets a default before the case so no path leaves a
  // signal unassigned, which would infer a latch.
  always_comb begin
    next_state = state;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    adr_src    = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    result_src = 2'b00;
    imm_src    = 3'b000;
    alu_op     = ALU_ADD;
    illegal    = 1'b0;

    case (state)
      S_FETCH: begin
        mem_req = 1'b1;
        if (ready) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          alu_src_b  = 2'b10;
          result_src = 2'b10;
          next_state = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        imm_src   = 3'b010;
        case (op)
          OP_LOAD, OP_STORE: next_state = S_MEMADR;
          OP_RTYPE:          next_state = S_EXECR;
          OP_ITYPE:          next_state = S_EXECI;
          OP_JAL:            next_state = S_JAL;
          OP_BRANCH:         next_state = (func3[2:1] == 2'b01) ? S_TRAP : S_BRANCH;
          default:           next_state = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        if (op == OP_STORE) begin
          imm_src    = 3'b001;
          next_state = S_MEMWRITE;
        end else begin
          next_state = S_MEMREAD;
        end
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        if (ready) next_state = S_MEMWB;
      end
      S_MEMWRITE: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        adr_src   = 1'b1;
        if (ready) next_state = S_FETCH;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        next_state = S_FETCH;
      end
      S_EXECR: begin
        alu_src_a  = 2'b10;
        alu_op     = decode_alu(func3, func7_5, 1'b1);
        next_state = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        alu_op     = decode_alu(func3, func7_5, 1'b0);
        next_state = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write  = 1'b1;
        next_state = S_FETCH;
      end
      S_JAL: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        imm_src    = 3'b011;
        pc_write   = 1'b1;
        next_state = S_ALUWB;
      end
      S_BRANCH: begin
        alu_src_a  = 2'b10;
        alu_op     = ALU_SUB;
        pc_write   = taken;
        next_state = S_FETCH;
      end
      S_TRAP: begin
        illegal = 1'b1;
      end
      default: next_state = S_FETCH;
    endcase

    // Reset forces FETCH asynchronously; also mask FETCH's request strobes.
    if (rst) begin
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      reg_write = 1'b0;
      mem_req   = 1'b0;
      mem_write = 1'b0;
      illegal   = 1'b0;
    end
  end

  assign alu_ctrl = ALU_CTRL_W'(alu_op);
  assign state_o  = state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: expected per-cycle control words
// are queued as each cycle is driven and compared when the DUT presents them.
module tb_multicycle_controller;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, irw, rw, mreq, mw, adr, ill;
    logic [1:0] a, b, res;
    logic [2:0] imm;
    logic [3:0] alu;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] op;
  logic [2:0] func3;
  logic       func7_5, alu_zero, alu_lt, alu_ltu, mem_ready;
  logic       pc_write, ir_write, reg_write, mem_req, mem_write, adr_src, illegal;
  logic [1:0] alu_src_a, alu_src_b, result_src;
  logic [2:0] imm_src;
  logic [3:0] alu_ctrl, state_o;

  always #5 clk = ~clk;

  multicycle_controller #(.ALU_CTRL_W(4), .MEM_READY_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .op(op), .func3(func3), .func7_5(func7_5),
    .alu_zero(alu_zero), .alu_lt(alu_lt), .alu_ltu(alu_ltu), .mem_ready(mem_ready),
    .pc_write(pc_write), .ir_write(ir_write), .reg_write(reg_write),
    .mem_req(mem_req), .mem_write(mem_write), .adr_src(adr_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .result_src(result_src),
    .imm_src(imm_src), .alu_ctrl(alu_ctrl), .illegal(illegal), .state_o(state_o)
  );

  int   n_checks = 0;
  int   n_errors = 0;
  obs_t exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic obs_t mk(input logic [3:0] st, input logic [6:0] sb,
                              input logic [1:0] a = 2'b00, input logic [1:0] b = 2'b00,
                              input logic [1:0] res = 2'b00, input logic [2:0] imm = 3'b000,
                              input logic [3:0] alu = 4'd0);
    obs_t o;
    o.st = st;
    {o.pcw, o.irw, o.rw, o.mreq, o.mw, o.adr, o.ill} = sb;
    o.a = a; o.b = b; o.res = res; o.imm = imm; o.alu = alu;
    return o;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.st = state_o;
    {o.pcw, o.irw, o.rw, o.mreq, o.mw, o.adr, o.ill} =
      {pc_write, ir_write, reg_write, mem_req, mem_write, adr_src, illegal};
    o.a = alu_src_a; o.b = alu_src_b; o.res = result_src; o.imm = imm_src; o.alu = alu_ctrl;
    return o;
  endfunction

  // Strobe field order: pc_write ir_write reg_write mem_req mem_write adr_src illegal
  obs_t F_RDY, F_WAIT, DEC, ADR_LD, ADR_ST, MRD, MWB, MWR, AWB, JAL, TRAP;

  // Called at posedge+1: drive the cycle, queue its expectation, compare mid-cycle.
  task automatic step(input string tag, input obs_t e, input logic rdy = 1'b1,
                      input logic z = 1'b0, input logic lt = 1'b0, input logic ltu = 1'b0);
    obs_t x;
    mem_ready = rdy; alu_zero = z; alu_lt = lt; alu_ltu = ltu;
    exp_q.push_back(e);
    @(negedge clk);
    x = exp_q.pop_front();
    check({tag, ".state"}, 32'(state_o), 32'(x.st));
    check({tag, ".ctrl"}, 32'(sample()), 32'(x));
    @(posedge clk); #1;
  endtask

  task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    op = o; func3 = f3; func7_5 = f7;
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    check({tag, ".rst_now"}, 32'({pc_write, ir_write, reg_write, mem_req, mem_write, illegal, state_o}), 32'd0);
    @(posedge clk); #1;
    check({tag, ".rst_held"}, 32'({pc_write, ir_write, reg_write, mem_req, mem_write, illegal, state_o}), 32'd0);
    rst = 1'b0;
  endtask

  typedef struct { logic [2:0] f3; logic f7; logic [3:0] alu; } alu_vec_t;
  typedef struct { logic [2:0] f3; logic z, lt, ltu, taken; } br_vec_t;

  initial begin
    alu_vec_t rvec[5], ivec[7];
    br_vec_t  bvec[9];

    F_RDY  = mk(4'd0, 7'b1101000, 2'b00, 2'b10, 2'b10);
    F_WAIT = mk(4'd0, 7'b0001000);
    DEC    = mk(4'd1, 7'b0000000, 2'b01, 2'b01, 2'b00, 3'b010);
    ADR_LD = mk(4'd2, 7'b0000000, 2'b10, 2'b01, 2'b00, 3'b000);
    ADR_ST = mk(4'd2, 7'b0000000, 2'b10, 2'b01, 2'b00, 3'b001);
    MRD    = mk(4'd3, 7'b0001010);
    MWB    = mk(4'd4, 7'b0010000, 2'b00, 2'b00, 2'b01);
    MWR    = mk(4'd5, 7'b0001110);
    AWB    = mk(4'd8, 7'b0010000);
    JAL    = mk(4'd9, 7'b1000000, 2'b01, 2'b10, 2'b00, 3'b011);
    TRAP   = mk(4'd11, 7'b0000001);

    rvec = '{'{3'b000, 1'b1, 4'd1}, '{3'b000, 1'b0, 4'd0}, '{3'b101, 1'b1, 4'd9},
             '{3'b111, 1'b0, 4'd2}, '{3'b010, 1'b0, 4'd5}};
    ivec = '{'{3'b000, 1'b1, 4'd0}, '{3'b101, 1'b0, 4'd8}, '{3'b101, 1'b1, 4'd9},
             '{3'b100, 1'b0, 4'd4}, '{3'b011, 1'b0, 4'd6}, '{3'b001, 1'b0, 4'd7},
             '{3'b110, 1'b0, 4'd3}};
    bvec = '{'{3'b000, 1'b1, 1'b0, 1'b0, 1'b1}, '{3'b000, 1'b0, 1'b0, 1'b0, 1'b0},
             '{3'b001, 1'b0, 1'b0, 1'b0, 1'b1}, '{3'b001, 1'b1, 1'b0, 1'b0, 1'b0},
             '{3'b100, 1'b0, 1'b1, 1'b0, 1'b1}, '{3'b101, 1'b0, 1'b1, 1'b0, 1'b0},
             '{3'b110, 1'b0, 1'b0, 1'b1, 1'b1}, '{3'b111, 1'b0, 1'b0, 1'b0, 1'b1},
             '{3'b111, 1'b0, 1'b0, 1'b1, 1'b0}};

    mem_ready = 1'b1; alu_zero = 1'b0; alu_lt = 1'b0; alu_ltu = 1'b0;
    set_instr(7'b0000011, 3'b010, 1'b0);
    do_reset("init");

    // lw with memory always ready
    step("lw.fetch", F_RDY);
    step("lw.decode", DEC);
    step("lw.memadr", ADR_LD);
    step("lw.memread", MRD);
    step("lw.memwb", MWB);

    // sw with a fetch stall and a three-cycle write stall
    set_instr(7'b0100011, 3'b010, 1'b0);
    step("sw.fetch_wait0", F_WAIT, 1'b0);
    step("sw.fetch_wait1", F_WAIT, 1'b0);
    step("sw.fetch", F_RDY);
    step("sw.decode", DEC);
    step("sw.memadr", ADR_ST);
    for (int i = 0; i < 3; i++) step($sformatf("sw.wait%0d", i), MWR, 1'b0);
    step("sw.write_done", MWR);

    foreach (rvec[i]) begin
      set_instr(7'b0110011, rvec[i].f3, rvec[i].f7);
      step($sformatf("r%0d.fetch", i), F_RDY);
      step($sformatf("r%0d.decode", i), DEC);
      step($sformatf("r%0d.execr", i), mk(4'd6, 7'b0, 2'b10, 2'b00, 2'b00, 3'b000, rvec[i].alu));
      step($sformatf("r%0d.aluwb", i), AWB);
    end

    foreach (ivec[i]) begin
      set_instr(7'b0010011, ivec[i].f3, ivec[i].f7);
      step($sformatf("i%0d.fetch", i), F_RDY);
      step($sformatf("i%0d.decode", i), DEC);
      step($sformatf("i%0d.execi", i), mk(4'd7, 7'b0, 2'b10, 2'b01, 2'b00, 3'b000, ivec[i].alu));
      step($sformatf("i%0d.aluwb", i), AWB);
    end

    set_instr(7'b1101111, 3'b000, 1'b0);
    step("jal.fetch", F_RDY);
    step("jal.decode", DEC);
    step("jal.jal", JAL);
    step("jal.aluwb", AWB);

    foreach (bvec[i]) begin
      set_instr(7'b1100011, bvec[i].f3, 1'b0);
      step($sformatf("b%0d.fetch", i), F_RDY);
      step($sformatf("b%0d.decode", i), DEC);
      step($sformatf("b%0d.branch", i),
           mk(4'd10, {bvec[i].taken, 6'b0}, 2'b10, 2'b00, 2'b00, 3'b000, 4'd1),
           1'b1, bvec[i].z, bvec[i].lt, bvec[i].ltu);
    end

    // op=0 traps; illegal holds for many cycles whatever the inputs do
    set_instr(7'b0000000, 3'b000, 1'b0);
    step("trap.fetch", F_RDY);
    step("trap.decode", DEC);
    for (int i = 0; i < 12; i++)
      step($sformatf("trap.hold%0d", i), TRAP, 1'(i % 2), 1'(i % 3 == 0));
    do_reset("trap");
    step("trap.after_rst", F_RDY);

    // branch with func3=010 is unsupported
    set_instr(7'b1100011, 3'b010, 1'b0);
    step("badbr.decode", DEC);
    step("badbr.trap", TRAP);
    do_reset("badbr");

    // reset in the middle of a stalled load read
    set_instr(7'b0000011, 3'b010, 1'b0);
    step("lrst.fetch", F_RDY);
    step("lrst.decode", DEC);
    step("lrst.memadr", ADR_LD);
    mem_ready = 1'b0;
    #1;
    check("lrst.in_memread", 32'(state_o), 32'd3);
    do_reset("lrst");
    step("lrst.after_rst", F_RDY);

    check("scoreboard.drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
